dmem_stall_ctrl: RTL and testbench



---
 rtl/dmem_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_dmem_stall_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stall_ctrl.sv
// Data-memory access controller: turns single-cycle MemRead/MemWrite requests into
// a valid/ready transaction on a variable-latency memory, stalling the datapath meanwhile.
module dmem_stall_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] Addr,
  input  logic [15:0] WriteData,
  output logic [15:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        Err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [15:0] rdata_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic        en_q;
  logic        done_q;
  logic        err_q;
  logic        stall_q;

  logic req;
  logic illegal;

  assign req     = MemRead | MemWrite;
  assign illegal = (MemRead & MemWrite) | Addr[0];

  // Only IDLE looks at the request inputs; every other state stalls from a flop.
  // Holding reset also masks the request so Stall shows its reset value.
  assign Stall = (state_q == S_IDLE) ? (req & ~rst) : stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here; pulse defaults below are overridden later in the same block.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            stall_q <= 1'b1;
            if (illegal) begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end else begin
              wr_q    <= MemWrite;
              addr_q  <= {Addr[15:1], 1'b0};
              wdata_q <= WriteData;
              cnt_q   <= '0;
              en_q    <= 1'b1;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A ready arriving on the last allowed cycle still completes the access.
          if (mem_ready) begin
            if (!wr_q) rdata_q <= mem_rdata;
            en_q    <= 1'b0;
            stall_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            en_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        S_ERR: begin
          stall_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ReadData  = rdata_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign mem_en    = en_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed bench for dmem_stall_ctrl (TIMEOUT=4): loads, stores, illegal accesses,
// timeout and its ready-wins boundary, reset mid-access, back-to-back loads.
module tb_dmem_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [15:0] Addr, WriteData;
  logic [15:0] ReadData;
  logic        Stall, Done, Err;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int passed = 0;
  int total  = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int hs_base, done_base;

  dmem_stall_ctrl #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Done      (Done),
    .Err       (Err),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // Memory handshakes and Done pulses as seen at each rising edge.
  always @(posedge clk) begin
    if (mem_en && mem_ready) hs_cnt++;
    if (Done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to 1ns after the next rising edge; inputs change there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational Stall settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Addr = 16'h0000; WriteData = 16'h0000;
    mem_rdata = 16'h0000; mem_ready = 1'b0;
    #12;
    chk("rst_stall",  {15'd0, Stall},  16'h0);
    chk("rst_en",     {15'd0, mem_en}, 16'h0);
    chk("rst_done",   {15'd0, Done},   16'h0);
    chk("rst_err",    {15'd0, Err},    16'h0);
    chk("rst_rdata",  ReadData,        16'h0000);
    chk("rst_addr",   mem_addr,        16'h0000);
    MemRead = 1'b0;
    #4 rst = 1'b0;
    tick();

    // Read 0x0010, ready on the third WAIT cycle.
    MemRead = 1'b1; Addr = 16'h0010; settle();
    chk("rd_req_stall", {15'd0, Stall},  16'h1);
    chk("rd_req_en",    {15'd0, mem_en}, 16'h0);
    tick();
    chk("rd_w1_en",   {15'd0, mem_en}, 16'h1);
    chk("rd_w1_addr", mem_addr,        16'h0010);
    chk("rd_w1_wr",   {15'd0, mem_wr}, 16'h0);
    chk("rd_w1_stall",{15'd0, Stall},  16'h1);
    tick();
    chk("rd_w2_stall",{15'd0, Stall},  16'h1);
    mem_rdata = 16'hBEEF;
    tick();
    mem_ready = 1'b1; settle();
    chk("rd_w3_stall",{15'd0, Stall},  16'h1);
    tick();
    mem_ready = 1'b0; MemRead = 1'b0; settle();
    chk("rd_done",    {15'd0, Done},   16'h1);
    chk("rd_dn_stall",{15'd0, Stall},  16'h0);
    chk("rd_dn_en",   {15'd0, mem_en}, 16'h0);
    chk("rd_data",    ReadData,        16'hBEEF);
    tick();
    chk("rd_idle_done", {15'd0, Done}, 16'h0);

    // Write 0x0022, ready on the first WAIT cycle.
    MemWrite = 1'b1; Addr = 16'h0022; WriteData = 16'h1234; settle();
    chk("wr_req_stall", {15'd0, Stall}, 16'h1);
    tick();
    chk("wr_en",    {15'd0, mem_en}, 16'h1);
    chk("wr_wr",    {15'd0, mem_wr}, 16'h1);
    chk("wr_wdata", mem_wdata,       16'h1234);
    chk("wr_addr",  mem_addr,        16'h0022);
    mem_ready = 1'b1; mem_rdata = 16'hAAAA;
    tick();
    mem_ready = 1'b0; MemWrite = 1'b0; settle();
    chk("wr_done",  {15'd0, Done},  16'h1);
    chk("wr_stall", {15'd0, Stall}, 16'h0);
    chk("wr_rdata_kept", ReadData,  16'hBEEF);
    tick();

    // Unaligned read.
    MemRead = 1'b1; Addr = 16'h0011; settle();
    chk("ua_stall", {15'd0, Stall}, 16'h1);
    tick();
    MemRead = 1'b0;
    chk("ua_err",    {15'd0, Err},    16'h1);
    chk("ua_stall1", {15'd0, Stall},  16'h1);
    chk("ua_en",     {15'd0, mem_en}, 16'h0);
    tick();
    chk("ua_err_off", {15'd0, Err},    16'h0);
    chk("ua_idle_en", {15'd0, mem_en}, 16'h0);
    chk("ua_idle_st", {15'd0, Stall},  16'h0);

    // Read and write together.
    MemRead = 1'b1; MemWrite = 1'b1; Addr = 16'h0030; settle();
    chk("rw_stall", {15'd0, Stall}, 16'h1);
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
    chk("rw_err", {15'd0, Err},    16'h1);
    chk("rw_en",  {15'd0, mem_en}, 16'h0);
    tick();
    chk("rw_err_off", {15'd0, Err}, 16'h0);

    // Timeout: ready never arrives; Err 4 cycles after WAIT entry.
    MemRead = 1'b1; Addr = 16'h0040;
    tick();
    chk("to_w1_en", {15'd0, mem_en}, 16'h1);
    tick(); tick(); tick();
    chk("to_w4_en",  {15'd0, mem_en}, 16'h1);
    chk("to_w4_err", {15'd0, Err},    16'h0);
    tick();
    MemRead = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hDEAD; settle();
    chk("to_err",   {15'd0, Err},    16'h1);
    chk("to_en",    {15'd0, mem_en}, 16'h0);
    chk("to_stall", {15'd0, Stall},  16'h1);
    tick();
    chk("to_late_done", {15'd0, Done}, 16'h0);
    chk("to_late_en",   {15'd0, mem_en}, 16'h0);
    tick();
    mem_ready = 1'b0;
    chk("to_late_done2", {15'd0, Done}, 16'h0);
    chk("to_rdata", ReadData, 16'hBEEF);

    // Ready on the last allowed WAIT cycle wins over the timeout.
    MemRead = 1'b1; Addr = 16'h0050; mem_rdata = 16'h5A5A;
    tick(); tick(); tick(); tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; MemRead = 1'b0;
    chk("bd_done",  {15'd0, Done}, 16'h1);
    chk("bd_err",   {15'd0, Err},  16'h0);
    chk("bd_rdata", ReadData,      16'h5A5A);
    tick();

    // Reset during WAIT, then a fresh read.
    MemRead = 1'b1; Addr = 16'h0060;
    tick();
    chk("rs_w_en", {15'd0, mem_en}, 16'h1);
    #2 rst = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hFFFF; settle();
    chk("rs_en",    {15'd0, mem_en}, 16'h0);
    chk("rs_stall", {15'd0, Stall},  16'h0);
    chk("rs_rdata", ReadData,        16'h0000);
    chk("rs_addr",  mem_addr,        16'h0000);
    tick();
    rst = 1'b0; mem_ready = 1'b0; settle();
    chk("rs_req_stall", {15'd0, Stall},  16'h1);
    chk("rs_req_en",    {15'd0, mem_en}, 16'h0);
    tick();
    chk("rs_addr2", mem_addr, 16'h0060);
    mem_ready = 1'b1; mem_rdata = 16'h0606;
    tick();
    mem_ready = 1'b0; MemRead = 1'b0;
    chk("rs_done",  {15'd0, Done}, 16'h1);
    chk("rs_rdata2", ReadData,     16'h0606);
    tick();

    // Back-to-back loads, request held high through DONE.
    hs_base = hs_cnt; done_base = done_cnt;
    MemRead = 1'b1; Addr = 16'h0000;
    tick();
    mem_ready = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ready = 1'b0; settle();
    chk("bb_done1",  {15'd0, Done}, 16'h1);
    chk("bb_rdata1", ReadData,      16'h1111);
    tick();
    Addr = 16'h0002; settle();
    chk("bb_req2_stall", {15'd0, Stall},  16'h1);
    chk("bb_req2_en",    {15'd0, mem_en}, 16'h0);
    tick();
    chk("bb_addr2", mem_addr, 16'h0002);
    mem_ready = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_ready = 1'b0; MemRead = 1'b0;
    chk("bb_done2",  {15'd0, Done}, 16'h1);
    chk("bb_rdata2", ReadData,      16'h2222);
    tick();
    chk("bb_idle_en", {15'd0, mem_en}, 16'h0);
    tick();
    chk("bb_hs",    16'(hs_cnt - hs_base),     16'd2);
    chk("bb_dones", 16'(done_cnt - done_base), 16'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
